// File: rtl/multi_trigger_sequencer_pkg.sv
// Shared types and default widths for the multi-channel trigger sequencer.
// Holds the per-channel state encoding and the configuration record.
package trigger_seq_pkg;

    localparam int DEF_NUM_CHANNELS = 4;
    localparam int DEF_DELAY_WIDTH  = 16;
    localparam int DEF_LENGTH_WIDTH = 16;
    localparam int DEF_REPEAT_WIDTH = 8;
    localparam int DEF_MISSED_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2,
        GAP   = 2'd3
    } chan_state_e;

    // Per-channel configuration record at the default field widths.
    typedef struct packed {
        logic [DEF_DELAY_WIDTH-1:0]  delay;
        logic [DEF_LENGTH_WIDTH-1:0] length;
        logic [DEF_REPEAT_WIDTH-1:0] repeatCount;
        logic [DEF_DELAY_WIDTH-1:0]  gap;
    } trigger_channel_cfg;

endpackage

// File: rtl/multi_trigger_sequencer_if.sv
// Configuration, trigger and status bundle of the multi-channel trigger sequencer.
// The master side drives configuration and the trigger; the slave side is the sequencer.
interface multi_trigger_sequencer_if
    import trigger_seq_pkg::*;
#(
    parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
    parameter int DELAY_WIDTH  = DEF_DELAY_WIDTH,
    parameter int LENGTH_WIDTH = DEF_LENGTH_WIDTH,
    parameter int REPEAT_WIDTH = DEF_REPEAT_WIDTH,
    parameter int MISSED_WIDTH = DEF_MISSED_WIDTH
);
    logic [NUM_CHANNELS-1:0]              ipEnable;
    logic [NUM_CHANNELS*DELAY_WIDTH-1:0]  ipDelay;
    logic [NUM_CHANNELS*LENGTH_WIDTH-1:0] ipLength;
    logic [NUM_CHANNELS*REPEAT_WIDTH-1:0] ipRepeat;
    logic [NUM_CHANNELS*DELAY_WIDTH-1:0]  ipGap;
    logic                                 ipClearMissed;
    logic                                 ipMasterTrigger;
    logic [NUM_CHANNELS-1:0]              opTrigger;
    logic [NUM_CHANNELS-1:0]              opBusy;
    logic [NUM_CHANNELS*MISSED_WIDTH-1:0] opMissed;

    modport master (
        output ipEnable, ipDelay, ipLength, ipRepeat, ipGap,
        output ipClearMissed, ipMasterTrigger,
        input  opTrigger, opBusy, opMissed
    );

    modport slave (
        input  ipEnable, ipDelay, ipLength, ipRepeat, ipGap,
        input  ipClearMissed, ipMasterTrigger,
        output opTrigger, opBusy, opMissed
    );
endinterface

// File: rtl/multi_trigger_sequencer_channel.sv
// One trigger channel: shadowed config, delay/pulse/gap burst FSM and
// a saturating missed-trigger counter.
module trigger_seq_channel
    import trigger_seq_pkg::*;
#(
    parameter int DELAY_WIDTH  = DEF_DELAY_WIDTH,
    parameter int LENGTH_WIDTH = DEF_LENGTH_WIDTH,
    parameter int REPEAT_WIDTH = DEF_REPEAT_WIDTH,
    parameter int MISSED_WIDTH = DEF_MISSED_WIDTH
) (
    input  logic                    ipClk,
    input  logic                    ipReset,
    input  logic                    ipEvent,
    input  logic                    ipEnable,
    input  logic [DELAY_WIDTH-1:0]  ipDelay,
    input  logic [LENGTH_WIDTH-1:0] ipLength,
    input  logic [REPEAT_WIDTH-1:0] ipRepeat,
    input  logic [DELAY_WIDTH-1:0]  ipGap,
    input  logic                    ipClearMissed,
    output logic                    opTrigger,
    output logic                    opBusy,
    output logic [MISSED_WIDTH-1:0] opMissed
);
    localparam int CNT_W = (DELAY_WIDTH > LENGTH_WIDTH) ? DELAY_WIDTH : LENGTH_WIDTH;

    chan_state_e             state_r;
    chan_state_e             stateNext_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W-1:0]        cntNext_s;
    logic [REPEAT_WIDTH-1:0] remain_r;
    logic [REPEAT_WIDTH-1:0] remainWork_s;
    logic [LENGTH_WIDTH-1:0] cfgLength_r;
    logic [LENGTH_WIDTH-1:0] lengthSel_s;
    logic [DELAY_WIDTH-1:0]  cfgGap_r;
    logic [DELAY_WIDTH-1:0]  gapSel_s;
    logic                    accept_s;
    logic                    goPulse_s;
    logic                    goEnd_s;
    logic                    trigger_r;
    logic                    busy_r;
    logic [MISSED_WIDTH-1:0] missed_r;

    // Next-state decode; zero-length pulses collapse so DELAY/GAP lead straight on.
    always_comb begin
        accept_s     = (state_r == IDLE) && ipEvent && ipEnable;
        stateNext_s  = state_r;
        cntNext_s    = cnt_r;
        remainWork_s = remain_r;
        goPulse_s    = 1'b0;
        goEnd_s      = 1'b0;
        if (accept_s) begin
            lengthSel_s = ipLength;
            gapSel_s    = (ipGap == {DELAY_WIDTH{1'b0}}) ? DELAY_WIDTH'(1'b1) : ipGap;
        end else begin
            lengthSel_s = cfgLength_r;
            gapSel_s    = cfgGap_r;
        end

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    remainWork_s = (ipRepeat == {REPEAT_WIDTH{1'b0}}) ? REPEAT_WIDTH'(1'b1) : ipRepeat;
                    if (ipDelay == {DELAY_WIDTH{1'b0}}) begin
                        goPulse_s = 1'b1;
                    end else begin
                        stateNext_s = DELAY;
                        cntNext_s   = CNT_W'(ipDelay);
                    end
                end else begin
                    stateNext_s = IDLE;
                end
            end
            DELAY, GAP: begin
                if (cnt_r == CNT_W'(1'b1)) begin
                    goPulse_s = 1'b1;
                end else begin
                    cntNext_s = cnt_r - CNT_W'(1'b1);
                end
            end
            PULSE: begin
                if (cnt_r == CNT_W'(1'b1)) begin
                    goEnd_s = 1'b1;
                end else begin
                    cntNext_s = cnt_r - CNT_W'(1'b1);
                end
            end
            default: begin
                stateNext_s = IDLE;
            end
        endcase

        if (goPulse_s) begin
            remainWork_s = remainWork_s - REPEAT_WIDTH'(1'b1);
            if (lengthSel_s != {LENGTH_WIDTH{1'b0}}) begin
                stateNext_s = PULSE;
                cntNext_s   = CNT_W'(lengthSel_s);
            end else begin
                goEnd_s = 1'b1;
            end
        end else begin
            remainWork_s = remainWork_s;
        end

        if (goEnd_s) begin
            if (remainWork_s != {REPEAT_WIDTH{1'b0}}) begin
                stateNext_s = GAP;
                cntNext_s   = CNT_W'(gapSel_s);
            end else begin
                stateNext_s = IDLE;
            end
        end else begin
            stateNext_s = stateNext_s;
        end

        // Losing enable aborts any burst in progress.
        if (!ipEnable) begin
            stateNext_s = IDLE;
        end else begin
            stateNext_s = stateNext_s;
        end
    end

    // State, counters, shadow config and registered outputs.
    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            remain_r    <= {REPEAT_WIDTH{1'b0}};
            cfgLength_r <= {LENGTH_WIDTH{1'b0}};
            cfgGap_r    <= {DELAY_WIDTH{1'b0}};
            trigger_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r   <= stateNext_s;
            cnt_r     <= cntNext_s;
            remain_r  <= remainWork_s;
            trigger_r <= (stateNext_s == PULSE);
            busy_r    <= (stateNext_s != IDLE);
            if (accept_s) begin
                cfgLength_r <= lengthSel_s;
                cfgGap_r    <= gapSel_s;
            end
        end
    end

    // Saturating missed-trigger counter; clear wins over a same-cycle increment.
    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            missed_r <= {MISSED_WIDTH{1'b0}};
        end else if (ipClearMissed) begin
            missed_r <= {MISSED_WIDTH{1'b0}};
        end else if (ipEvent && ipEnable && (state_r != IDLE) && (missed_r != {MISSED_WIDTH{1'b1}})) begin
            missed_r <= missed_r + MISSED_WIDTH'(1'b1);
        end
    end

    assign opTrigger = trigger_r;
    assign opBusy    = busy_r;
    assign opMissed  = missed_r;

endmodule

// File: rtl/multi_trigger_sequencer.sv
// Multi-channel trigger sequencer: master-trigger edge detect fanned out to
// NUM_CHANNELS independently configured burst channels.
module multi_trigger_sequencer
    import trigger_seq_pkg::*;
#(
    parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
    parameter int DELAY_WIDTH  = DEF_DELAY_WIDTH,
    parameter int LENGTH_WIDTH = DEF_LENGTH_WIDTH,
    parameter int REPEAT_WIDTH = DEF_REPEAT_WIDTH,
    parameter int MISSED_WIDTH = DEF_MISSED_WIDTH
) (
    input  logic                      ipClk,
    input  logic                      ipReset,
    multi_trigger_sequencer_if.slave  bus
);
    logic                    trigPrev_r;
    logic                    event_s;
    logic [NUM_CHANNELS-1:0] trigger_s;
    logic [NUM_CHANNELS-1:0] busy_s;
    logic [NUM_CHANNELS*MISSED_WIDTH-1:0] missed_s;

    // Previous master trigger level for rising-edge detection.
    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            trigPrev_r <= 1'b0;
        end else begin
            trigPrev_r <= bus.ipMasterTrigger;
        end
    end

    assign event_s = bus.ipMasterTrigger & ~trigPrev_r;

    for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : gChannel
        trigger_seq_channel #(
            .DELAY_WIDTH  (DELAY_WIDTH),
            .LENGTH_WIDTH (LENGTH_WIDTH),
            .REPEAT_WIDTH (REPEAT_WIDTH),
            .MISSED_WIDTH (MISSED_WIDTH)
        ) uChannel (
            .ipClk         (ipClk),
            .ipReset       (ipReset),
            .ipEvent       (event_s),
            .ipEnable      (bus.ipEnable[ch]),
            .ipDelay       (bus.ipDelay[ch*DELAY_WIDTH +: DELAY_WIDTH]),
            .ipLength      (bus.ipLength[ch*LENGTH_WIDTH +: LENGTH_WIDTH]),
            .ipRepeat      (bus.ipRepeat[ch*REPEAT_WIDTH +: REPEAT_WIDTH]),
            .ipGap         (bus.ipGap[ch*DELAY_WIDTH +: DELAY_WIDTH]),
            .ipClearMissed (bus.ipClearMissed),
            .opTrigger     (trigger_s[ch]),
            .opBusy        (busy_s[ch]),
            .opMissed      (missed_s[ch*MISSED_WIDTH +: MISSED_WIDTH])
        );
    end

    assign bus.opTrigger = trigger_s;
    assign bus.opBusy    = busy_s;
    assign bus.opMissed  = missed_s;

endmodule
